// File: rtl/data_ram_ctrl.sv
// Handshaked RV64 data memory: funct3-decoded byte/half/word/double access,
// configurable response latency, misalignment and illegal-funct3 error response.
module data_ram_ctrl #(
  parameter int ADDR_WIDTH       = 12,
  parameter int LATENCY          = 1,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [63:0] pend_rdata;
  logic        pend_err;

  logic [7:0]  mem [DEPTH];

  logic        accept;
  logic [7:0]  byte_en;
  logic [2:0]  align_mask;
  logic        illegal;
  logic        misaligned;
  logic        acc_err;
  logic [63:0] raw;
  logic [63:0] load_data;

  assign accept = req_valid && req_ready;

  always_comb begin
    byte_en    = 8'h01;
    align_mask = 3'd0;
    case (req_funct3[1:0])
      2'd0: begin byte_en = 8'h01; align_mask = 3'd0; end
      2'd1: begin byte_en = 8'h03; align_mask = 3'd1; end
      2'd2: begin byte_en = 8'h0F; align_mask = 3'd3; end
      default: begin byte_en = 8'hFF; align_mask = 3'd7; end
    endcase
    illegal    = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    misaligned = |(req_addr[2:0] & align_mask);
    acc_err    = illegal || (!ALLOW_MISALIGNED && misaligned);
  end

  // Gather eight bytes starting at req_addr; the index wraps at the top of memory.
  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      raw[8*k +: 8] = mem[req_addr + ADDR_WIDTH'(k)];
    end
  end

  always_comb begin
    load_data = '0;
    case (req_funct3)
      3'b000:  load_data = {{56{raw[7]}}, raw[7:0]};
      3'b001:  load_data = {{48{raw[15]}}, raw[15:0]};
      3'b010:  load_data = {{32{raw[31]}}, raw[31:0]};
      3'b011:  load_data = raw;
      3'b100:  load_data = {56'd0, raw[7:0]};
      3'b101:  load_data = {48'd0, raw[15:0]};
      3'b110:  load_data = {32'd0, raw[31:0]};
      default: load_data = '0;
    endcase
    if (req_we || acc_err) begin
      load_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && req_we && !acc_err) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (byte_en[k]) begin
          mem[req_addr + ADDR_WIDTH'(k)] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Load data is captured at accept and parked in pend_* until the counter expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (LATENCY <= 1) begin
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
              resp_err   <= acc_err;
            end else begin
              state      <= WAIT;
              cnt        <= 3'(LATENCY - 1);
              req_ready  <= 1'b0;
              pend_rdata <= load_data;
              pend_err   <= acc_err;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_rdata <= pend_rdata;
            resp_err   <= pend_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Randomised self-checking bench for data_ram_ctrl: three instances covering
// latency 3/1/4 and strict/relaxed alignment against a byte-array reference model.
module tb_data_ram_ctrl;

  localparam int LAT [3] = '{3, 1, 4};
  localparam int MIS [3] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [11:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic        resp_valid [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  logic [7:0]  mm [3][4096];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.ADDR_WIDTH(12), .LATENCY(3), .ALLOW_MISALIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]));

  data_ram_ctrl #(.ADDR_WIDTH(12), .LATENCY(1), .ALLOW_MISALIGNED(1'b1)) dut_b (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]));

  data_ram_ctrl #(.ADDR_WIDTH(12), .LATENCY(4), .ALLOW_MISALIGNED(1'b0)) dut_c (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: access size from funct3, error rules, byte-wise little-endian memory.
  task automatic model(input int i, input bit we, input int f3, input int addr,
                       input logic [63:0] wd, output logic [63:0] rd, output logic err);
    int size;
    bit illegal;
    logic [63:0] val;
    size    = 1 << (f3 % 4);
    illegal = we ? (f3 >= 4) : (f3 == 7);
    err     = illegal || (MIS[i] == 0 && (addr % size) != 0);
    rd      = 64'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < size; k++) mm[i][(addr + k) % 4096] = 8'((wd >> (8 * k)) & 64'hFF);
      end else begin
        val = 64'd0;
        for (int k = 0; k < size; k++) val = val | (64'(mm[i][(addr + k) % 4096]) << (8 * k));
        if (f3 < 3 && ((val >> (8 * size - 1)) & 64'd1) == 64'd1) val = val - (64'd1 << (8 * size));
        rd = val;
      end
    end
  endtask

  // Issue one request, wait for the response and check timing, data and error.
  task automatic xact(input int i, input bit we, input logic [2:0] f3, input logic [11:0] addr,
                      input logic [63:0] wd, input string tag, output logic [63:0] got);
    logic [63:0] erd;
    logic        eerr;
    int          n;
    model(i, we, int'(f3), int'(addr), wd, erd, eerr);
    check({tag, "/ready_before"}, 64'(req_ready[i]), 64'd1);
    req_valid[i] = 1'b1; req_we[i] = we; req_funct3[i] = f3;
    req_addr[i] = addr; req_wdata[i] = wd;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 0;
    while (resp_valid[i] !== 1'b1 && n < 20) begin
      check({tag, "/busy"}, 64'(req_ready[i]), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'(LAT[i] - 1));
    check({tag, "/rdata"}, resp_rdata[i], erd);
    check({tag, "/err"}, 64'(resp_err[i]), 64'(eerr));
    check({tag, "/ready_resp"}, 64'(req_ready[i]), 64'd1);
    got = resp_rdata[i];
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] erd;
    logic        eerr;
    logic [63:0] exp4 [4];
    logic [11:0] a4   [4];

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b011;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("reset/ready", 64'(req_ready[0]), 64'd1);
      check("reset/valid", 64'(resp_valid[0]), 64'd0);
      check("reset/rdata", resp_rdata[0], 64'd0);
      check("reset/err", 64'(resp_err[0]), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; req_valid[i] = 1'b0;
    end

    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 512; a++)
        xact(i, 1'b1, 3'b011, 12'(a * 8), {$urandom, $urandom}, "init", got);

    // Store presented during reset must not be written.
    rst[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b011;
    req_addr[0] = 12'h040; req_wdata[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rstvalid/ready", 64'(req_ready[0]), 64'd1);
      check("rstvalid/valid", 64'(resp_valid[0]), 64'd0);
    end
    rst[0] = 1'b0; req_valid[0] = 1'b0;
    xact(0, 1'b0, 3'b011, 12'h040, '0, "rstvalid/nowrite", got);

    xact(0, 1'b1, 3'b011, 12'h010, 64'h8877665544332211, "sd", got);
    check("sd/rdata_zero", got, 64'd0);
    xact(0, 1'b0, 3'b011, 12'h010, '0, "ld", got);
    check("ld/const", got, 64'h8877665544332211);
    xact(0, 1'b0, 3'b000, 12'h017, '0, "lb", got);
    check("lb/const", got, 64'hFFFFFFFFFFFFFF88);
    xact(0, 1'b0, 3'b100, 12'h017, '0, "lbu", got);
    check("lbu/const", got, 64'h88);
    xact(0, 1'b0, 3'b010, 12'h014, '0, "lw", got);
    check("lw/const", got, 64'hFFFFFFFF88776655);
    xact(0, 1'b0, 3'b110, 12'h014, '0, "lwu", got);
    check("lwu/const", got, 64'h0000000088776655);

    xact(0, 1'b0, 3'b011, 12'h020, '0, "pre_mis", got);
    erd = got;
    xact(0, 1'b1, 3'b010, 12'h021, 64'hDEADBEEF, "sw_mis", got);
    check("sw_mis/err_direct", 64'(resp_err[0]), 64'd1);
    xact(0, 1'b0, 3'b011, 12'h020, '0, "post_mis", got);
    check("post_mis/unchanged", got, erd);
    xact(0, 1'b0, 3'b111, 12'h020, '0, "ld_f3_111", got);
    check("ld_f3_111/err_direct", 64'(resp_err[0]), 64'd1);
    xact(0, 1'b1, 3'b101, 12'h020, 64'h1234, "st_f3_101", got);

    // Four back-to-back loads at LATENCY=1 with req_valid held high.
    for (int j = 0; j < 4; j++) begin
      a4[j] = 12'($urandom_range(0, 511) * 8);
      model(1, 1'b0, 3, int'(a4[j]), '0, exp4[j], eerr);
    end
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b011;
    for (int j = 0; j < 4; j++) begin
      req_addr[1] = a4[j];
      @(posedge clk); #1;
      check("b2b/valid", 64'(resp_valid[1]), 64'd1);
      check("b2b/rdata", resp_rdata[1], exp4[j]);
    end
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("b2b/valid_end", 64'(resp_valid[1]), 64'd0);
    check("b2b/rdata_end", resp_rdata[1], 64'd0);

    xact(1, 1'b1, 3'b001, 12'hFFF, 64'hBEEF, "sh_wrap", got);
    xact(1, 1'b0, 3'b100, 12'hFFF, '0, "wrap_b0", got);
    check("wrap_b0/const", got, 64'hEF);
    xact(1, 1'b0, 3'b100, 12'h000, '0, "wrap_b1", got);
    check("wrap_b1/const", got, 64'hBE);
    xact(1, 1'b0, 3'b101, 12'hFFF, '0, "lhu_wrap", got);
    check("lhu_wrap/const", got, 64'hBEEF);

    // Reset one cycle after a store accept: response dropped, store kept.
    model(2, 1'b1, 0, 12'h030, 64'h5A, erd, eerr);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'b000;
    req_addr[2] = 12'h030; req_wdata[2] = 64'h5A;
    @(posedge clk); #1;
    req_valid[2] = 1'b0; rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    check("midrst/ready", 64'(req_ready[2]), 64'd1);
    for (int c = 0; c < 6; c++) begin
      check("midrst/no_valid", 64'(resp_valid[2]), 64'd0);
      @(posedge clk); #1;
    end
    xact(2, 1'b0, 3'b100, 12'h030, '0, "midrst/lbu", got);
    check("midrst/const", got, 64'h5A);

    for (int i = 0; i < 3; i++)
      for (int t = 0; t < 300; t++)
        xact(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             12'($urandom_range(0, 4095)), {$urandom, $urandom}, "rand", got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Parametrised, handshaked RV64 data memory for the scpu load/store path. It replaces the fixed 4 KiB, single-latency data RAM with four changes:
- configurable depth and response latency;
- a valid/ready request interface with one-cycle response pulses;
- misalignment and illegal-funct3 detection;
- an error response.

It sits between the core's MEM stage and the byte-addressed backing array, and decodes RISC-V funct3 for all byte/half/word/double loads and stores.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width; depth = 2**ADDR_WIDTH bytes.
- LATENCY, 1, cycles from request accept to response; legal range 1..8.
- ALLOW_MISALIGNED, 0, 0 = misaligned access is an error; 1 = performed bytewise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the access.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  64  store data, little-endian; low bytes are used.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  64  load result, sign/zero-extended; 0 for stores and errors.
- resp_err  out  1  access rejected; qualified by resp_valid.

## Operation
- **Clock and reset:** one clock domain, clk; rst is synchronous, active-high.
- **Accept:** a request is accepted at a rising edge where req_valid && req_ready. Request fields are sampled only at that edge.
- **FSM states:** IDLE, WAIT.
  - IDLE: req_ready=1. On accept, go to WAIT and load the latency counter with LATENCY-1.
  - WAIT: req_ready=0, counter decrements each cycle.
  - The edge at which the counter would reach 0 produces resp_valid=1 for the following cycle, with req_ready=1 in that same cycle (state IDLE).
  - With LATENCY=1 the block never enters WAIT and sustains one request per cycle.
- **Store widths (req_we=1):**
  - funct3 000 sb: 1 byte; 001 sh: 2 bytes; 010 sw: 4 bytes; 011 sd: 8 bytes.
  - funct3 1xx is illegal and sets resp_err.
- **Load widths (req_we=0):**
  - 000 lb, 001 lh, 010 lw: sign-extended.
  - 011 ld: 8 bytes.
  - 100 lbu, 101 lhu, 110 lwu: zero-extended.
  - 111 is illegal and sets resp_err.
- **Byte order:** little-endian; byte k of the access lives at (req_addr + k) mod 2**ADDR_WIDTH, so accesses wrap around the top of memory.
- **Alignment:** an access is misaligned when req_addr is not a multiple of its size. With ALLOW_MISALIGNED=0, a misaligned access sets resp_err=1, performs no write and returns resp_rdata=0. With ALLOW_MISALIGNED=1 it is performed normally, including wrap-around.
- **Store commit:** store bytes are written into the array at the accept edge. A later request always observes them.
- **Load capture:** load data is read from the array as of the accept edge, held in a response register through the latency, and presented with resp_valid.
- **Store response:** resp_valid=1, resp_rdata=0, resp_err=0.
- **Memory contents:** not cleared by rst and undefined at power-up. The bench must write before reading.

## Timing
- **Reset values:** req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, counter=0.
- **Response timing:** resp_valid is high exactly one cycle, LATENCY cycles after the accept edge. There is no response back-pressure; the consumer must take the response that cycle.
- **Output hold:** resp_rdata and resp_err are valid only while resp_valid=1. At all other times they are driven to 0.
- **Reset mid-operation:** an in-flight response is dropped: resp_valid stays 0 and the block returns to IDLE. A store accepted before the reset edge remains committed.
- **rst and req_valid together:** rst wins; no accept, no write.
- **Back-to-back:** when a response cycle coincides with a new accept, the response for the old request is emitted and the new request starts its latency count in the same cycle.
- **Erroneous requests:** consume the same LATENCY as legal ones.

## Test plan
- **Reset:** LATENCY=3, drive rst for 2 cycles with req_valid=1 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; no write occurs.
- **Store/load round trip:**
  - sd 0x8877665544332211 at 0x010, then ld 0x010 -> resp_rdata=0x8877665544332211.
  - lb 0x017 -> 0xFFFFFFFFFFFFFF88.
  - lbu 0x017 -> 0x88.
  - lw 0x014 -> 0xFFFFFFFF88776655.
  - lwu 0x014 -> 0x0000000088776655.
- **Latency/handshake:**
  - LATENCY=3: accept at edge 0 -> req_ready=0 for 2 cycles; resp_valid=1 only in the 3rd cycle, with req_ready=1.
  - LATENCY=1: 4 back-to-back loads -> 4 consecutive resp_valid pulses.
- **Misaligned, ALLOW_MISALIGNED=0:**
  - sw 0xDEADBEEF at 0x021 -> resp_err=1; a subsequent ld 0x020 is unchanged from its prior value.
  - funct3=111 load -> resp_err=1, resp_rdata=0.
- **Misaligned with wrap, ALLOW_MISALIGNED=1, ADDR_WIDTH=12:** sh 0xBEEF at 0xFFF -> byte 0xFFF=0xEF, byte 0x000=0xBE; lhu 0xFFF -> 0xBEEF.
- **Reset mid-operation, LATENCY=4:** accept sb 0x5A at 0x030, assert rst one cycle later -> no resp_valid; after reset, lbu 0x030 -> 0x5A.
